fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- pc_en  in  1  PC advance enable from hazard unit
- if_id_pipeline_en  in  1  IF/ID load enable
- if_id_pipeline_flush  in  1  IF/ID bubble insert
- modify_pc  in  1  redirect request
- pc_target  in  32  redirect address
- imem_ready  in  1  instruction memory response valid
- imem_rdata  in  32  instruction word
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- if_id_pc  out  32  IF/ID PC
- if_id_instr  out  32  IF/ID instruction
- if_id_valid  out  1  IF/ID slot holds a real instruction
- fetch_stall  out  1  fetch waiting on memory

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, HOLD and DROP.
REQ-005 IDLE SHALL be entered only from reset and SHALL go to FETCH on the first clock edge after reset release.
REQ-006 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-007 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-008 FETCH, imem_ready=1, pc_en=1, if_id_pipeline_en=1: SHALL load IF/ID with {pc, imem_rdata, valid=1}, set pc to pc+4 and stay in FETCH, giving one-cycle latency and back-to-back issue.
REQ-009 FETCH, imem_ready=1, either enable 0: SHALL capture imem_rdata into a hold buffer, go to HOLD and hold pc.
REQ-010 In HOLD, imem_req SHALL be 0.
REQ-011 HOLD, pc_en=1 and if_id_pipeline_en=1: SHALL load IF/ID from the hold buffer with valid=1, set pc to pc+4 and go to FETCH.
REQ-012 FETCH, imem_ready=0, if_id_pipeline_en=1: SHALL load IF/ID with a bubble {pc, 32'h0000_0013, valid=0}.
REQ-013 Whenever if_id_pipeline_en=0 and no flush is active, IF/ID SHALL hold its contents.
REQ-014 if_id_pipeline_flush=1 SHALL load the IF/ID bubble regardless of if_id_pipeline_en; flush SHALL win over enable=0.
REQ-015 modify_pc=1 SHALL have priority over all other events and SHALL set pc to {pc_target[31:2], 2'b00}.
REQ-016 On modify_pc=1, any hold-buffer contents and any same-cycle imem_rdata SHALL be discarded.
REQ-017 modify_pc=1 while in FETCH with imem_ready=0 SHALL go to DROP.
- In DROP, imem_req SHALL stay 1 with the old address until imem_ready=1.
- That returning data SHALL be discarded.
- The FSM SHALL then go to FETCH at the redirected pc.
REQ-018 modify_pc=1 in any other state SHALL go to FETCH with the new pc on the next cycle.
REQ-019 pc SHALL wrap modulo 2^32, so 32'hFFFF_FFFC+4 SHALL give 32'h0000_0000.
REQ-020 fetch_stall SHALL equal (state==FETCH and imem_ready==0) or state==DROP, computed combinationally.

Reset
REQ-021 rst_n low SHALL asynchronously set:
- pc=RESET_PC
- state=IDLE
- imem_req=0
- imem_addr=RESET_PC
- if_id_pc=0, if_id_instr=32'h0000_0013, if_id_valid=0
- hold buffer=0
REQ-022 Reset asserted mid-transaction SHALL abandon any outstanding request, with no response tracking after release.

Configuration
REQ-023 With macro FETCH_PERF_CNT_EN defined, the block SHALL add these 32-bit wrapping output ports, reset to 0:
- perf_stall_cnt  out  32  increments each cycle fetch_stall=1
- perf_redirect_cnt  out  32  increments each cycle modify_pc=1
REQ-024 With FETCH_PERF_CNT_EN undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-025 Reset release, imem_ready tied 1, enables 1 -> imem_addr sequence 0,4,8.
- if_id_valid=1 from the second cycle.
- if_id_pc lags imem_addr by one cycle.
REQ-026 Data returned in FETCH, if_id_pipeline_en=0 and pc_en=0 for 2 cycles, then 1 -> state goes to HOLD and imem_req=0.
- On release, IF/ID gets the buffered word.
- No word is lost or duplicated.
REQ-027 modify_pc=1, pc_target=32'h0000_0103, during imem_ready=0 -> state goes to DROP.
- The late response is discarded.
- The next request has imem_addr=32'h0000_0100.
REQ-028 if_id_pipeline_flush=1 with if_id_pipeline_en=0 -> the next cycle shows if_id_instr=32'h0000_0013 and if_id_valid=0.
REQ-029 RESET_PC=32'hFFFF_FFFC -> the second fetch address is 32'h0000_0000.
REQ-030 FETCH_PERF_CNT_EN defined, 3 stall cycles and 1 redirect -> perf_stall_cnt=3 and perf_redirect_cnt=1.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if -- instruction-memory request/response bus.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : 32-bit fetch address, held while a request is outstanding
//   imem_ready : response valid for the outstanding request (slave -> master)
//   imem_rdata : 32-bit instruction word returned with imem_ready
// The master modport is used by the fetch unit, the slave modport by memory.
// ----------------------------------------------------------------------------
interface fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage with IF/ID pipeline register.
//
// Fetches instructions from memory through fetch_unit_if (master side), buffers
// a returned word when the pipeline is stalled, and redirects on modify_pc.
// A redirect issued while a request is still outstanding drains that response
// in DROP before fetching from the new address.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pc_en                 PC advance enable from the hazard unit
//   if_id_pipeline_en     IF/ID load enable
//   if_id_pipeline_flush  IF/ID bubble insert (wins over enable)
//   modify_pc, pc_target  redirect request and its target address
//   imem_bus              instruction memory bus (req/addr/ready/rdata)
//   if_id_pc/instr/valid  IF/ID pipeline register contents
//   fetch_stall           combinational: fetch waiting on memory
//
// Parameter:
//   RESET_PC              first fetch address after reset
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_stall_cnt        wrapping count of cycles with fetch_stall=1
//   perf_redirect_cnt     wrapping count of cycles with modify_pc=1
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_en,
    input  logic                if_id_pipeline_en,
    input  logic                if_id_pipeline_flush,
    input  logic                modify_pc,
    input  logic [31:0]         pc_target,
    fetch_unit_if.master        imem_bus,
    output logic [31:0]         if_id_pc,
    output logic [31:0]         if_id_instr,
    output logic                if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_redirect_cnt,
`endif
    output logic                fetch_stall
);

    localparam int unsigned      XLEN      = 32;
    localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0]  PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;

    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] redirect_pc;
    logic            bubble;
    logic            load_word;
    logic [XLEN-1:0] word;

    // Target is word-aligned; the low bits are intentionally ignored.
    logic unused_pc_target_lsbs;
    assign unused_pc_target_lsbs = ^pc_target[1:0];

    assign pc_inc      = pc_q + PC_STEP;
    assign redirect_pc = {pc_target[XLEN-1:2], 2'b00};

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            hold_q        <= '0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_q        <= hold_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // Next-state, PC, hold buffer and IF/ID update.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        bubble        = 1'b0;
        load_word     = 1'b0;
        word          = NOP_INSTR;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (modify_pc) begin
                    // Same-cycle data is dropped; an unanswered request must drain first.
                    pc_d    = redirect_pc;
                    hold_d  = '0;
                    state_d = imem_bus.imem_ready ? FETCH : DROP;
                    bubble  = if_id_pipeline_en;
                end else if (imem_bus.imem_ready) begin
                    if (pc_en && if_id_pipeline_en) begin
                        load_word = 1'b1;
                        word      = imem_bus.imem_rdata;
                        pc_d      = pc_inc;
                    end else begin
                        hold_d  = imem_bus.imem_rdata;
                        state_d = HOLD;
                        bubble  = if_id_pipeline_en;
                    end
                end else begin
                    bubble = if_id_pipeline_en;
                end
            end

            HOLD: begin
                if (modify_pc) begin
                    pc_d    = redirect_pc;
                    hold_d  = '0;
                    state_d = FETCH;
                    bubble  = if_id_pipeline_en;
                end else if (pc_en && if_id_pipeline_en) begin
                    load_word = 1'b1;
                    word      = hold_q;
                    pc_d      = pc_inc;
                    hold_d    = '0;
                    state_d   = FETCH;
                end else begin
                    bubble = if_id_pipeline_en;
                end
            end

            DROP: begin
                // A further redirect while draining just retargets the pc.
                if (modify_pc) begin
                    pc_d   = redirect_pc;
                    hold_d = '0;
                end
                if (imem_bus.imem_ready) begin
                    state_d = FETCH;
                end
                bubble = if_id_pipeline_en;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush overrides any load or hold of the IF/ID register.
        if (if_id_pipeline_flush || bubble) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (load_word) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = word;
            if_id_valid_d = 1'b1;
        end
    end

    // Request registers: address frozen while draining in DROP.
    always_comb begin
        imem_req_d  = (state_d == FETCH) || (state_d == DROP);
        imem_addr_d = (state_d == DROP) ? imem_addr_q : pc_d;
    end

    assign imem_bus.imem_req  = imem_req_q;
    assign imem_bus.imem_addr = imem_addr_q;

    assign fetch_stall = ((state_q == FETCH) && !imem_bus.imem_ready) || (state_q == DROP);

    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] perf_stall_q;
    logic [XLEN-1:0] perf_redirect_q;

    // Free-running wrapping event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q    <= '0;
            perf_redirect_q <= '0;
        end else begin
            if (fetch_stall) begin
                perf_stall_q <= perf_stall_q + XLEN'(1);
            end
            if (modify_pc) begin
                perf_redirect_q <= perf_redirect_q + XLEN'(1);
            end
        end
    end

    assign perf_stall_cnt    = perf_stall_q;
    assign perf_redirect_cnt = perf_redirect_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// Memory model returns 32'hA000_0000 | addr for any address. A second instance
// with RESET_PC = 32'hFFFF_FFFC exercises pc wrap-around.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_en;
    logic        ifid_en;
    logic        flush;
    logic        modify_pc;
    logic [31:0] pc_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_stall;

    logic [31:0] w_if_id_pc;
    logic [31:0] w_if_id_instr;
    logic        w_if_id_valid;
    logic        w_fetch_stall;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redirect_cnt;
    logic [31:0] w_perf_stall_cnt;
    logic [31:0] w_perf_redirect_cnt;
`endif

    int n_checks;
    int n_fail;

    fetch_unit_if bus0 ();
    fetch_unit_if bus1 ();

    assign bus0.imem_rdata = 32'hA000_0000 | bus0.imem_addr;
    assign bus1.imem_rdata = 32'hA000_0000 | bus1.imem_addr;
    assign bus1.imem_ready = 1'b1;

    fetch_unit dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pc_en                (pc_en),
        .if_id_pipeline_en    (ifid_en),
        .if_id_pipeline_flush (flush),
        .modify_pc            (modify_pc),
        .pc_target            (pc_target),
        .imem_bus             (bus0),
        .if_id_pc             (if_id_pc),
        .if_id_instr          (if_id_instr),
        .if_id_valid          (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cnt       (perf_stall_cnt),
        .perf_redirect_cnt    (perf_redirect_cnt),
`endif
        .fetch_stall          (fetch_stall)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pc_en                (1'b1),
        .if_id_pipeline_en    (1'b1),
        .if_id_pipeline_flush (1'b0),
        .modify_pc            (1'b0),
        .pc_target            (32'h0000_0000),
        .imem_bus             (bus1),
        .if_id_pc             (w_if_id_pc),
        .if_id_instr          (w_if_id_instr),
        .if_id_valid          (w_if_id_valid),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cnt       (w_perf_stall_cnt),
        .perf_redirect_cnt    (w_perf_redirect_cnt),
`endif
        .fetch_stall          (w_fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        pc_en            = 1'b1;
        ifid_en          = 1'b1;
        flush            = 1'b0;
        modify_pc        = 1'b0;
        pc_target        = 32'h0;
        bus0.imem_ready  = 1'b1;

        // Reset values
        #12;
        check("rst_req",    32'(bus0.imem_req), 32'd0);
        check("rst_addr",   bus0.imem_addr,     32'h0000_0000);
        check("rst_ifpc",   if_id_pc,           32'h0000_0000);
        check("rst_instr",  if_id_instr,        32'h0000_0013);
        check("rst_valid",  32'(if_id_valid),   32'd0);
        check("rst_waddr",  bus1.imem_addr,     32'hFFFF_FFFC);
        rst_n = 1'b1;

        // Streaming fetch 0,4,8
        tick();
        check("s0_req",     32'(bus0.imem_req), 32'd1);
        check("s0_addr",    bus0.imem_addr,     32'h0000_0000);
        check("s0_valid",   32'(if_id_valid),   32'd0);
        check("w0_addr",    bus1.imem_addr,     32'hFFFF_FFFC);
        tick();
        check("s1_addr",    bus0.imem_addr,     32'h0000_0004);
        check("s1_ifpc",    if_id_pc,           32'h0000_0000);
        check("s1_instr",   if_id_instr,        32'hA000_0000);
        check("s1_valid",   32'(if_id_valid),   32'd1);
        check("w1_addr",    bus1.imem_addr,     32'h0000_0000);
        check("w1_ifpc",    w_if_id_pc,         32'hFFFF_FFFC);
        tick();
        check("s2_addr",    bus0.imem_addr,     32'h0000_0008);
        check("s2_ifpc",    if_id_pc,           32'h0000_0004);
        check("s2_instr",   if_id_instr,        32'hA000_0004);

        // Stall two cycles with a returned word -> HOLD
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        tick();
        check("h0_req",     32'(bus0.imem_req), 32'd0);
        check("h0_ifpc",    if_id_pc,           32'h0000_0004);
        check("h0_instr",   if_id_instr,        32'hA000_0004);
        tick();
        check("h1_req",     32'(bus0.imem_req), 32'd0);
        check("h1_valid",   32'(if_id_valid),   32'd1);
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        tick();
        check("h2_ifpc",    if_id_pc,           32'h0000_0008);
        check("h2_instr",   if_id_instr,        32'hA000_0008);
        check("h2_req",     32'(bus0.imem_req), 32'd1);
        check("h2_addr",    bus0.imem_addr,     32'h0000_000C);
        tick();
        check("h3_instr",   if_id_instr,        32'hA000_000C);
        check("h3_addr",    bus0.imem_addr,     32'h0000_0010);

        // Memory wait -> bubble, then redirect while waiting -> DROP
        bus0.imem_ready = 1'b0;
        tick();
        check("w_stall",    32'(fetch_stall),   32'd1);
        check("w_addr",     bus0.imem_addr,     32'h0000_0010);
        check("w_valid",    32'(if_id_valid),   32'd0);
        check("w_instr",    if_id_instr,        32'h0000_0013);
        modify_pc = 1'b1;
        pc_target = 32'h0000_0103;
        tick();
        check("d0_addr",    bus0.imem_addr,     32'h0000_0010);
        check("d0_req",     32'(bus0.imem_req), 32'd1);
        check("d0_stall",   32'(fetch_stall),   32'd1);
        modify_pc = 1'b0;
        tick();
        check("d1_stall",   32'(fetch_stall),   32'd1);
        check("d1_addr",    bus0.imem_addr,     32'h0000_0010);
        bus0.imem_ready = 1'b1;
        tick();
        check("d2_addr",    bus0.imem_addr,     32'h0000_0100);
        check("d2_valid",   32'(if_id_valid),   32'd0);
        check("d2_stall",   32'(fetch_stall),   32'd0);
        tick();
        check("d3_ifpc",    if_id_pc,           32'h0000_0100);
        check("d3_instr",   if_id_instr,        32'hA000_0100);
        check("d3_addr",    bus0.imem_addr,     32'h0000_0104);

        // Flush wins over enable=0
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        flush   = 1'b1;
        tick();
        check("f0_instr",   if_id_instr,        32'h0000_0013);
        check("f0_valid",   32'(if_id_valid),   32'd0);
        check("f0_req",     32'(bus0.imem_req), 32'd0);
        flush   = 1'b0;
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        tick();
        check("f1_ifpc",    if_id_pc,           32'h0000_0104);
        check("f1_instr",   if_id_instr,        32'hA000_0104);
        check("f1_addr",    bus0.imem_addr,     32'h0000_0108);

        // Reset during an outstanding request
        bus0.imem_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("r_req",      32'(bus0.imem_req), 32'd0);
        check("r_stall",    32'(fetch_stall),   32'd0);
        check("r_addr",     bus0.imem_addr,     32'h0000_0000);
        check("r_valid",    32'(if_id_valid),   32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("r1_req",     32'(bus0.imem_req), 32'd1);
        check("r1_addr",    bus0.imem_addr,     32'h0000_0000);
        check("r1_stall",   32'(fetch_stall),   32'd1);

        // Three stall cycles, then one redirect with ready=1
        repeat (3) tick();
        bus0.imem_ready = 1'b1;
        modify_pc       = 1'b1;
        pc_target       = 32'h0000_0040;
        tick();
        modify_pc = 1'b0;
        check("p_addr",     bus0.imem_addr,     32'h0000_0040);
        check("p_valid",    32'(if_id_valid),   32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("p_stall_cnt",    perf_stall_cnt,    32'd3);
        check("p_redirect_cnt", perf_redirect_cnt, 32'd1);
`endif
        tick();
        check("p1_ifpc",    if_id_pc,           32'h0000_0040);
        check("p1_instr",   if_id_instr,        32'hA000_0040);
`ifdef FETCH_PERF_CNT_EN
        check("p1_stall_cnt",    perf_stall_cnt,    32'd3);
        check("p1_redirect_cnt", perf_redirect_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
